// File: rtl/pwm_fader.sv
// pwm_fader: multi-channel PWM with a shared prescaler and duty updates only at period boundaries.
// Define PWM_FADER_RAMP_EN to fade each duty toward its target by at most RAMP_STEP per period.
module pwm_fader #(
    parameter int CHANNELS      = 4,
    parameter int BITS          = 10,
    parameter int MAX_VALUE     = 1000,
    parameter int PRESCALE      = 250,
    parameter int PRESCALE_BITS = 8,
    parameter int RAMP_STEP     = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     load,
    input  logic [CHANNELS*BITS-1:0] target,
    output logic [CHANNELS-1:0]      out,
    output logic [CHANNELS*BITS-1:0] duty,
    output logic [CHANNELS-1:0]      settled,
    output logic                     period_start
);

`ifdef PWM_FADER_RAMP_EN
    localparam int STEP_LIMIT = RAMP_STEP;
`else
    // Without fading every boundary jumps straight to the shadow: a step at least the full range.
    localparam int STEP_LIMIT = (RAMP_STEP > MAX_VALUE) ? RAMP_STEP : MAX_VALUE;
`endif
    localparam int STEP_SAT = (STEP_LIMIT < MAX_VALUE) ? STEP_LIMIT : MAX_VALUE;

    localparam logic [PRESCALE_BITS-1:0] PRESC_LAST = PRESCALE_BITS'(PRESCALE - 1);
    localparam logic [PRESCALE_BITS-1:0] PRESC_ONE  = PRESCALE_BITS'(1);
    localparam logic [BITS-1:0]          COUNT_LAST = BITS'(MAX_VALUE - 1);
    localparam logic [BITS-1:0]          COUNT_ONE  = BITS'(1);
    localparam logic [BITS-1:0]          MAX_DUTY   = BITS'(MAX_VALUE);
    localparam logic [BITS:0]            STEP_W     = (BITS + 1)'(STEP_SAT);

    logic [PRESCALE_BITS-1:0] r_presc;
    logic [BITS-1:0]          r_count;
    logic                     r_run;
    logic                     r_periodStart;
    logic [CHANNELS-1:0]      r_out;
    logic [BITS-1:0]          r_duty   [CHANNELS];
    logic [BITS-1:0]          r_shadow [CHANNELS];

    logic w_tick;
    logic w_boundary;

    function automatic logic [BITS-1:0] clampTarget(input logic [BITS-1:0] t);
        return (t > MAX_DUTY) ? MAX_DUTY : t;
    endfunction

    function automatic logic [BITS-1:0] stepToward(input logic [BITS-1:0] cur,
                                                   input logic [BITS-1:0] goal);
        logic [BITS:0] curW;
        logic [BITS:0] goalW;
        logic [BITS:0] nextW;
        curW  = {1'b0, cur};
        goalW = {1'b0, goal};
        nextW = curW;
        if (goalW > curW) begin
            nextW = ((curW + STEP_W) < goalW) ? (curW + STEP_W) : goalW;
        end else if (curW > goalW) begin
            nextW = (curW > (goalW + STEP_W)) ? (curW - STEP_W) : goalW;
        end
        return BITS'(nextW);
    endfunction

    assign w_tick     = enable && r_run && (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_count == COUNT_LAST);

    // Counters sit at zero for the first enabled cycle, which is the cycle that announces the new period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc       <= '0;
            r_count       <= '0;
            r_run         <= 1'b0;
            r_periodStart <= 1'b0;
        end else if (!enable) begin
            r_presc       <= '0;
            r_count       <= '0;
            r_run         <= 1'b0;
            r_periodStart <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_periodStart <= w_boundary || !r_run;
            if (w_tick) begin
                r_presc <= '0;
                r_count <= w_boundary ? '0 : (r_count + COUNT_ONE);
            end else if (r_run) begin
                r_presc <= r_presc + PRESC_ONE;
            end
        end
    end

    // A load in the boundary cycle lands in the shadow after the boundary has already sampled it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load) begin
                    r_shadow[i] <= clampTarget(target[i*BITS +: BITS]);
                end
                if (w_boundary) begin
                    r_duty[i] <= stepToward(r_duty[i], r_shadow[i]);
                end
                r_out[i] <= enable && r_run && (r_count < r_duty[i]);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign duty[g*BITS +: BITS] = r_duty[g];
        assign settled[g]           = (r_duty[g] == r_shadow[g]);
    end

    assign out          = r_out;
    assign period_start = r_periodStart;

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: vector table, hand-written corner sequences and a randomized run against a behavioural model.
// Expectations follow the PWM_FADER_RAMP_EN setting the design is compiled with.
module tb_pwm_fader;

    localparam int CH    = 2;
    localparam int BITS  = 4;
    localparam int MAXV  = 10;
    localparam int PRE   = 2;
    localparam int PREB  = 2;
    localparam int STEP  = 4;
    localparam int PER   = PRE * MAXV;

    logic                 clock   = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable  = 1'b0;
    logic                 load    = 1'b0;
    logic [CH*BITS-1:0]   target  = '0;
    logic [CH-1:0]        out;
    logic [CH*BITS-1:0]   duty;
    logic [CH-1:0]        settled;
    logic                 period_start;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        int         t0;
        int         t1;
        int         periods;
        int         d0;
        int         d1;
        logic [1:0] set;
    } vec_t;

    vec_t vecs[6];

    pwm_fader #(
        .CHANNELS(CH), .BITS(BITS), .MAX_VALUE(MAXV), .PRESCALE(PRE),
        .PRESCALE_BITS(PREB), .RAMP_STEP(STEP)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .load(load), .target(target),
        .out(out), .duty(duty), .settled(settled), .period_start(period_start)
    );

    always #5 clock = ~clock;

    // Reference: a period is PER clocks counted from the first running cycle; count = phase / PRE.
    int          mDuty   [CH];
    int          mShadow [CH];
    logic [CH-1:0] mOut = '0;
    int          mPhase = 0;
    bit          mRun   = 1'b0;
    bit          mPs    = 1'b0;

    function automatic int refClamp(input int t);
        return (t > MAXV) ? MAXV : t;
    endfunction

    function automatic int refStep(input int d, input int s);
`ifdef PWM_FADER_RAMP_EN
        if (d < s) return (s - d > STEP) ? d + STEP : s;
        if (d > s) return (d - s > STEP) ? d - STEP : s;
        return d;
`else
        return s;
`endif
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                mDuty[i]   <= 0;
                mShadow[i] <= 0;
            end
            mOut   <= '0;
            mPhase <= 0;
            mRun   <= 1'b0;
            mPs    <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                mOut[i] <= enable && mRun && ((mPhase / PRE) < mDuty[i]);
                if (enable && mRun && mPhase == PER - 1) mDuty[i] <= refStep(mDuty[i], mShadow[i]);
                if (load) mShadow[i] <= refClamp(int'(target[i*BITS +: BITS]));
            end
            mPs    <= (enable && mRun && mPhase == PER - 1) || (enable && !mRun);
            mPhase <= (enable && mRun) ? (mPhase + 1) % PER : 0;
            mRun   <= enable;
        end
    end

    function automatic logic [CH*BITS-1:0] packT(input int a, input int b);
        logic [CH*BITS-1:0] v;
        v = {BITS'(b), BITS'(a)};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [CH*BITS-1:0] tgt);
        @(posedge clock);
        #1;
        enable = en;
        load   = ld;
        target = tgt;
    endtask

    task automatic waitPs(input int n);
        for (int k = 0; k < n; k++) begin
            int budget;
            bit seen;
            budget = 0;
            seen   = 1'b0;
            while (!seen && budget < 3 * PER) begin
                @(negedge clock);
                budget++;
                seen = period_start;
            end
            if (!seen) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL waitPs timeout: period_start got 0 expected 1 at %0t", $time);
            end
        end
    endtask

    task automatic doReset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        load    = 1'b0;
        enable  = 1'b1;
        #2;
        checkOutput("reset out", out, 0);
        checkOutput("reset duty", duty, 0);
        checkOutput("reset settled", settled, 2'b11);
        checkOutput("reset period_start", period_start, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic modelCheck();
        logic [CH*BITS-1:0] eDuty;
        logic [CH-1:0]      eSet;
        for (int i = 0; i < CH; i++) begin
            eDuty[i*BITS +: BITS] = BITS'(mDuty[i]);
            eSet[i]               = (mDuty[i] == mShadow[i]);
        end
        checkOutput("model out", out, mOut);
        checkOutput("model duty", duty, eDuty);
        checkOutput("model settled", settled, eSet);
        checkOutput("model period_start", period_start, mPs);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expD[3];
        int expS[3];

`ifdef PWM_FADER_RAMP_EN
        vecs[0] = '{5, 0, 1, 4, 0, 2'b10};
        vecs[1] = '{5, 0, 1, 5, 0, 2'b11};
        vecs[2] = '{15, 3, 1, 9, 3, 2'b10};
        vecs[3] = '{0, 10, 1, 5, 7, 2'b00};
        vecs[4] = '{7, 7, 0, 5, 7, 2'b10};
        vecs[5] = '{7, 7, 1, 7, 7, 2'b11};
        expD = '{4, 8, 10};
        expS = '{0, 0, 1};
`else
        vecs[0] = '{5, 0, 1, 5, 0, 2'b11};
        vecs[1] = '{5, 0, 0, 5, 0, 2'b11};
        vecs[2] = '{15, 3, 1, 10, 3, 2'b11};
        vecs[3] = '{0, 10, 1, 0, 10, 2'b11};
        vecs[4] = '{7, 7, 0, 0, 10, 2'b00};
        vecs[5] = '{7, 7, 1, 7, 7, 2'b11};
        expD = '{10, 10, 10};
        expS = '{1, 1, 1};
`endif
        $display("[TB] start: period %0d clocks, ramp step %0d", PER, STEP);

        doReset();
        foreach (vecs[v]) begin
            waitPs(1);
            applyStimulus(1'b1, 1'b1, packT(vecs[v].t0, vecs[v].t1));
            applyStimulus(1'b1, 1'b0, target);
            if (vecs[v].periods == 0) @(negedge clock);
            else waitPs(vecs[v].periods);
            checkOutput($sformatf("vec%0d duty0", v), duty[0 +: BITS], vecs[v].d0);
            checkOutput($sformatf("vec%0d duty1", v), duty[BITS +: BITS], vecs[v].d1);
            checkOutput($sformatf("vec%0d settled", v), settled, vecs[v].set);
        end

        // 50% waveform on ch0, ch1 idle
        doReset();
        applyStimulus(1'b1, 1'b1, packT(5, 0));
        applyStimulus(1'b1, 1'b0, target);
        waitPs(2);
        for (int k = 0; k < PER; k++) begin
            checkOutput($sformatf("wave out0 k%0d", k), out[0], (k >= 1 && k <= 10));
            checkOutput($sformatf("wave out1 k%0d", k), out[1], 0);
            checkOutput($sformatf("wave ps k%0d", k), period_start, (k == 0));
            @(negedge clock);
        end
        checkOutput("wave ps next period", period_start, 1);

        // full scale, then an over-range load that must clamp
        applyStimulus(1'b1, 1'b1, packT(10, 0));
        applyStimulus(1'b1, 1'b0, target);
        waitPs(3);
        applyStimulus(1'b1, 1'b1, packT(15, 0));
        applyStimulus(1'b1, 1'b0, target);
        @(negedge clock);
        checkOutput("clamp settled", settled, 2'b11);
        for (int k = 0; k < 2 * PER; k++) begin
            checkOutput("full-scale out0", out[0], 1);
            @(negedge clock);
        end
        checkOutput("clamp duty0", duty[0 +: BITS], 10);

        // fade from 0 to 10
        doReset();
        applyStimulus(1'b1, 1'b1, packT(10, 0));
        applyStimulus(1'b1, 1'b0, target);
        for (int b = 0; b < 3; b++) begin
            waitPs(1);
            checkOutput($sformatf("fade duty0 b%0d", b), duty[0 +: BITS], expD[b]);
            checkOutput($sformatf("fade settled0 b%0d", b), settled[0], expS[b]);
        end

        // load in the boundary cycle keeps the old shadow for that boundary
        repeat (PER - 1) @(posedge clock);
        #1;
        load   = 1'b1;
        target = packT(2, 0);
        applyStimulus(1'b1, 1'b0, target);
        @(negedge clock);
        checkOutput("bnd-load ps", period_start, 1);
        checkOutput("bnd-load duty0 kept", duty[0 +: BITS], 10);
        checkOutput("bnd-load settled0", settled[0], 0);
        waitPs(1);
`ifdef PWM_FADER_RAMP_EN
        checkOutput("bnd-load duty0 next", duty[0 +: BITS], 6);
`else
        checkOutput("bnd-load duty0 next", duty[0 +: BITS], 2);
`endif
        waitPs(1);
        checkOutput("bnd-load duty0 final", duty[0 +: BITS], 2);

        // enable drop mid-period and restart
        doReset();
        applyStimulus(1'b1, 1'b1, packT(5, 0));
        applyStimulus(1'b1, 1'b0, target);
        waitPs(2);
        repeat (4) applyStimulus(1'b1, 1'b0, target);
        applyStimulus(1'b0, 1'b0, target);
        @(negedge clock);
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            checkOutput("disabled out", out, 0);
            checkOutput("disabled duty0", duty[0 +: BITS], 5);
            checkOutput("disabled ps", period_start, 0);
        end
        applyStimulus(1'b1, 1'b0, target);
        for (int j = 0; j < 22; j++) begin
            @(negedge clock);
            checkOutput($sformatf("restart ps j%0d", j), period_start, (j == 1 || j == 21));
            checkOutput($sformatf("restart out0 j%0d", j), out[0], (j >= 2 && j <= 11));
        end

        // asynchronous reset in the middle of a fade
        doReset();
        applyStimulus(1'b1, 1'b1, packT(10, 0));
        applyStimulus(1'b1, 1'b0, target);
        waitPs(2);
        repeat (3) @(posedge clock);
        #3;
        checkOutput("pre-reset out0", out[0], 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset out", out, 0);
        checkOutput("async reset duty", duty, 0);
        checkOutput("async reset ps", period_start, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post-reset settled", settled, 2'b11);
        checkOutput("post-reset duty", duty, 0);

        // randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            reset_n = ($urandom_range(0, 399) != 0);
            enable  = ($urandom_range(0, 15) != 0);
            load    = ($urandom_range(0, 5) == 0);
            target  = packT($urandom_range(0, 15), $urandom_range(0, 15));
            @(negedge clock);
            modelCheck();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
